// File: rtl/blink_tick_gen_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the blink tick generator: rate encodings,
// debounce FSM states and the rate-to-period mapping.
package blink_tick_gen_pkg;

  typedef enum logic [1:0] {
    RATE_1HZ    = 2'd0,
    RATE_2HZ    = 2'd1,
    RATE_4HZ    = 2'd2,
    RATE_HALFHZ = 2'd3
  } rate_e;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam logic [1:0] RATE_STEP = 2'd1;

  // Blink period in clock cycles for a given rate index.
  function automatic int unsigned period_cycles(input rate_e rate, input int unsigned clk_freq);
    case (rate)
      RATE_2HZ:    return clk_freq / 2;
      RATE_4HZ:    return clk_freq / 4;
      RATE_HALFHZ: return 2 * clk_freq;
      default:     return clk_freq;
    endcase
  endfunction

endpackage

// File: rtl/blink_tick_gen_btn_debounce.sv
`timescale 1ns/1ps
// Push-button front end: 2-flop synchronizer followed by a press/release
// debounce FSM. press_set_o is the combinational "press accepted this cycle"
// strobe; btn_press_o is its registered one-cycle pulse.
module btn_debounce
  import blink_tick_gen_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic nbtn_i,
  output logic press_set_o,
  output logic btn_press_o
);

  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            btn_press_q;

  // Bring the asynchronous, active-low button into the clock domain (idle high).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= nbtn_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM state, stable-time counter and registered press pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      btn_press_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_press_q <= press_set_o;
    end
  end

  // Next-state logic: a level must hold for DB_CYCLES samples to be accepted.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_set_o = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = RELEASED;
        end else if (cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          press_set_o = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      PRESSED: begin
        if (sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign btn_press_o = btn_press_q;

endmodule

// File: rtl/blink_tick_gen.sv
`timescale 1ns/1ps
// Blink tick generator: a debounced button steps through four blink rates,
// and a period counter emits a one-cycle transition pulse per blink period.
module blink_tick_gen
  import blink_tick_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nBTN,
  input  logic       run_en,
  output logic       transition,
  output logic [1:0] rate_sel,
  output logic       btn_press
);

  localparam int unsigned CNT_W = $clog2(2 * CLK_FREQ);

  localparam logic [CNT_W-1:0] TC_1HZ    = CNT_W'(period_cycles(RATE_1HZ,    CLK_FREQ) - 1);
  localparam logic [CNT_W-1:0] TC_2HZ    = CNT_W'(period_cycles(RATE_2HZ,    CLK_FREQ) - 1);
  localparam logic [CNT_W-1:0] TC_4HZ    = CNT_W'(period_cycles(RATE_4HZ,    CLK_FREQ) - 1);
  localparam logic [CNT_W-1:0] TC_HALFHZ = CNT_W'(period_cycles(RATE_HALFHZ, CLK_FREQ) - 1);

  logic             press_set;
  rate_e            rate_q, rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tc;
  logic             at_tc;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk_i       (CLK),
    .rst_i       (RST),
    .nbtn_i      (nBTN),
    .press_set_o (press_set),
    .btn_press_o (btn_press)
  );

  // Terminal count of the period counter for the active rate.
  always_comb begin
    case (rate_q)
      RATE_2HZ:    tc = TC_2HZ;
      RATE_4HZ:    tc = TC_4HZ;
      RATE_HALFHZ: tc = TC_HALFHZ;
      default:     tc = TC_1HZ;
    endcase
  end

  // Rate stepping and period counting; a rate change restarts the period and
  // takes priority over a coincident terminal count.
  always_comb begin
    at_tc      = (cnt_q == tc);
    rate_d     = rate_q;
    cnt_d      = cnt_q;
    transition = run_en && at_tc && !press_set && !RST;
    if (press_set) begin
      rate_d = rate_e'(rate_q + RATE_STEP);
      cnt_d  = '0;
    end else if (run_en) begin
      cnt_d = at_tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Rate register and period counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rate_q <= RATE_1HZ;
      cnt_q  <= '0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rate_sel = rate_q;

endmodule

// File: tb/tb_blink_tick_gen.sv
`timescale 1ns/1ps
// Bench for blink_tick_gen with CLK_FREQ=8, DB_CYCLES=4 (periods 8/4/2/16).
// Cycle n is the clock period following the n-th rising edge after reset
// release; expected pulse cycles are queued up front and compared against the
// pulses the DUT actually produced.
module tb_blink_tick_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       nBTN = 1'b1;
  logic       run_en = 1'b0;
  logic       transition;
  logic [1:0] rate_sel;
  logic       btn_press;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s_cyc;
  logic       s_tr, s_bp;
  logic [1:0] s_rate;
  int exp_tr[$], obs_tr[$], exp_bp[$], obs_bp[$];
  int e, o;

  blink_tick_gen #(
    .CLK_FREQ  (8),
    .DB_CYCLES (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .nBTN       (nBTN),
    .run_en     (run_en),
    .transition (transition),
    .rate_sel   (rate_sel),
    .btn_press  (btn_press)
  );

  always #5 CLK = ~CLK;

  // Sample the current cycle at the falling edge, then advance one cycle.
  task automatic tick();
    @(negedge CLK);
    s_cyc  = cyc;
    s_tr   = transition;
    s_bp   = btn_press;
    s_rate = rate_sel;
    if (s_tr === 1'b1) obs_tr.push_back(cyc);
    if (s_bp === 1'b1) obs_bp.push_back(cyc);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1; nBTN = 1'b1; run_en = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    cyc = 0;
    obs_tr.delete(); obs_bp.delete(); exp_tr.delete(); exp_bp.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_tr !== 1'b0) begin errors++; $display("FAIL reset_transition: got %b, required 0", s_tr); end
    checks++; if (s_bp !== 1'b0) begin errors++; $display("FAIL reset_btn_press: got %b, required 0", s_bp); end
    checks++; if (s_rate !== 2'd0) begin errors++; $display("FAIL reset_rate_sel: got %0d, required 0", s_rate); end
  endtask

  task automatic test_basic();
    do_reset();
    exp_tr = '{7, 15, 23, 31, 39};
    for (int k = 0; k < 40; k++) begin
      run_en = 1'b1; nBTN = 1'b1;
      tick();
    end
    checks++; if (s_rate !== 2'd0) begin errors++; $display("FAIL basic_rate_sel: got %0d, required 0", s_rate); end
    while (exp_tr.size() > 0 || obs_tr.size() > 0) begin
      checks++;
      e = (exp_tr.size() > 0) ? exp_tr.pop_front() : -1;
      o = (obs_tr.size() > 0) ? obs_tr.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL basic_transition: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
    while (exp_bp.size() > 0 || obs_bp.size() > 0) begin
      checks++;
      e = (exp_bp.size() > 0) ? exp_bp.pop_front() : -1;
      o = (obs_bp.size() > 0) ? obs_bp.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL basic_btn_press: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    exp_tr = '{7, 15, 22, 26, 30, 34, 38, 42};
    exp_bp = '{19};
    for (int k = 0; k < 46; k++) begin
      run_en = 1'b1;
      if (k < 12) nBTN = ((k / 2) % 2 == 1);
      else        nBTN = (k >= 32);
      tick();
      if (s_cyc == 18) begin
        checks++; if (s_rate !== 2'd0) begin errors++; $display("FAIL bounce_rate_before: got %0d, required 0", s_rate); end
      end
      if (s_cyc == 19) begin
        checks++; if (s_rate !== 2'd1) begin errors++; $display("FAIL bounce_rate_after: got %0d, required 1", s_rate); end
      end
    end
    while (exp_tr.size() > 0 || obs_tr.size() > 0) begin
      checks++;
      e = (exp_tr.size() > 0) ? exp_tr.pop_front() : -1;
      o = (obs_tr.size() > 0) ? obs_tr.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL bounce_transition: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
    while (exp_bp.size() > 0 || obs_bp.size() > 0) begin
      checks++;
      e = (exp_bp.size() > 0) ? exp_bp.pop_front() : -1;
      o = (obs_bp.size() > 0) ? obs_bp.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL bounce_btn_press: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
  endtask

  task automatic test_rates();
    logic [1:0] want;
    do_reset();
    exp_tr = '{10, 14, 18, 22, 28, 30, 32, 34, 36, 38, 40, 42, 44, 62, 78, 94, 102, 110};
    exp_bp = '{7, 27, 47, 87};
    for (int k = 0; k < 113; k++) begin
      run_en = 1'b1;
      nBTN = !(((k % 20) < 10 && k < 60) || (k >= 80 && k < 90));
      tick();
      if (s_cyc == 8 || s_cyc == 28 || s_cyc == 48 || s_cyc == 88) begin
        want = (s_cyc == 8) ? 2'd1 : (s_cyc == 28) ? 2'd2 : (s_cyc == 48) ? 2'd3 : 2'd0;
        checks++;
        if (s_rate !== want) begin errors++; $display("FAIL rates_rate_sel: cycle %0d got %0d, required %0d", s_cyc, s_rate, want); end
      end
    end
    while (exp_tr.size() > 0 || obs_tr.size() > 0) begin
      checks++;
      e = (exp_tr.size() > 0) ? exp_tr.pop_front() : -1;
      o = (obs_tr.size() > 0) ? obs_tr.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL rates_transition: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
    while (exp_bp.size() > 0 || obs_bp.size() > 0) begin
      checks++;
      e = (exp_bp.size() > 0) ? exp_bp.pop_front() : -1;
      o = (obs_bp.size() > 0) ? obs_bp.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL rates_btn_press: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
  endtask

  task automatic test_run_en();
    do_reset();
    exp_tr = '{17, 28, 36};
    for (int k = 0; k < 41; k++) begin
      nBTN = 1'b1;
      run_en = !((k >= 5 && k <= 14) || (k >= 25 && k <= 27));
      tick();
    end
    while (exp_tr.size() > 0 || obs_tr.size() > 0) begin
      checks++;
      e = (exp_tr.size() > 0) ? exp_tr.pop_front() : -1;
      o = (obs_tr.size() > 0) ? obs_tr.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL run_en_transition: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
    while (exp_bp.size() > 0 || obs_bp.size() > 0) begin
      checks++;
      e = (exp_bp.size() > 0) ? exp_bp.pop_front() : -1;
      o = (obs_bp.size() > 0) ? obs_bp.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL run_en_btn_press: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
  endtask

  task automatic test_press_at_tc();
    do_reset();
    exp_tr = '{11, 15, 19};
    exp_bp = '{8};
    for (int k = 0; k < 21; k++) begin
      run_en = 1'b1;
      nBTN = !(k >= 1 && k <= 10);
      tick();
      if (s_cyc == 8) begin
        checks++; if (s_rate !== 2'd1) begin errors++; $display("FAIL press_tc_rate_sel: got %0d, required 1", s_rate); end
      end
    end
    while (exp_tr.size() > 0 || obs_tr.size() > 0) begin
      checks++;
      e = (exp_tr.size() > 0) ? exp_tr.pop_front() : -1;
      o = (obs_tr.size() > 0) ? obs_tr.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL press_tc_transition: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
    while (exp_bp.size() > 0 || obs_bp.size() > 0) begin
      checks++;
      e = (exp_bp.size() > 0) ? exp_bp.pop_front() : -1;
      o = (obs_bp.size() > 0) ? obs_bp.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL press_tc_btn_press: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exp_tr = '{10, 14, 18, 22, 28, 30, 32, 34, 36, 38, 40, 42, 53, 61};
    exp_bp = '{7, 27};
    for (int k = 0; k < 63; k++) begin
      run_en = 1'b1;
      RST = (k == 44 || k == 45);
      nBTN = !((k < 10) || (k >= 20 && k < 30) || (k >= 40 && k < 44));
      tick();
      if (s_cyc == 43) begin
        checks++; if (s_rate !== 2'd2) begin errors++; $display("FAIL reset_mid_rate_before: got %0d, required 2", s_rate); end
      end
      if (s_cyc == 45) begin
        checks++; if (s_rate !== 2'd0) begin errors++; $display("FAIL reset_mid_rate_in_reset: got %0d, required 0", s_rate); end
        checks++; if (s_tr !== 1'b0) begin errors++; $display("FAIL reset_mid_transition_in_reset: got %b, required 0", s_tr); end
      end
      if (s_cyc == 62) begin
        checks++; if (s_rate !== 2'd0) begin errors++; $display("FAIL reset_mid_rate_after: got %0d, required 0", s_rate); end
      end
    end
    while (exp_tr.size() > 0 || obs_tr.size() > 0) begin
      checks++;
      e = (exp_tr.size() > 0) ? exp_tr.pop_front() : -1;
      o = (obs_tr.size() > 0) ? obs_tr.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL reset_mid_transition: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
    while (exp_bp.size() > 0 || obs_bp.size() > 0) begin
      checks++;
      e = (exp_bp.size() > 0) ? exp_bp.pop_front() : -1;
      o = (obs_bp.size() > 0) ? obs_bp.pop_front() : -1;
      if (o !== e) begin errors++; $display("FAIL reset_mid_btn_press: pulse at cycle %0d, required %0d (-1 = none)", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_rates();
    test_run_en();
    test_press_at_tc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
